hazard_controller: RTL

- Hazard and sequencing controller for the 5-stage MIPS pipeline.
- Generates execute-stage forwarding selects and decode-stage branch-compare forwarding.
- Generates stall and flush for fetch, decode, execute and memory stages.
- Sequences a multi-cycle multiply/divide occupancy of the execute stage: freezes the front end until the operation completes, then releases it.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/hazard_controller_if.sv | 47 ++++
 rtl/md_sequencer.sv | 67 ++++++
 rtl/hazard_controller.sv | 76 +++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline hazard controller:
// forwarding selects, the mult/div sequencer state and a forwarding helper.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  // Execute-stage operand select; the younger (M) producer wins over W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic [4:0] wreg_m,
                                         input logic       wen_m,
                                         input logic [4:0] wreg_w,
                                         input logic       wen_w);
    logic [1:0] sel;
    sel = FWD_RF;
    if (src != REG_ZERO && wen_m && wreg_m == src)
      sel = FWD_MEM;
    else if (src != REG_ZERO && wen_w && wreg_w == src)
      sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline side,
// slave = controller. HAZARD_PERF_CNT_EN adds the performance counter outputs.
// Handshake: none; every signal is a level sampled each cycle, no valid/ready.
interface hazard_controller_if #(parameter int PERF_W = 32);
  import mips_pkg::*;

  logic [4:0] Rs_D, Rt_D, Rs_E, Rt_E;
  logic [4:0] writeReg_E, writeReg_M, writeReg_W;
  logic       regWrite_E, regWrite_M, regWrite_W;
  logic       memToReg_E, memToReg_M;
  logic       branch_D, pcSrc_D, md_start_E;

  logic [1:0] forwardA_E, forwardB_E;
  logic       forwardA_D, forwardB_D;
  logic       stall_F, stall_D, stall_E;
  logic       flush_D, flush_E, flush_M;
  logic       md_busy, md_done;
  md_state_t  md_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles, flush_count;
`endif

  modport master (
    output Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, writeReg_M, writeReg_W,
           regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M,
           branch_D, pcSrc_D, md_start_E,
    input  forwardA_E, forwardB_E, forwardA_D, forwardB_D,
           stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
           md_busy, md_done, md_state
`ifdef HAZARD_PERF_CNT_EN
         , stall_cycles, flush_count
`endif
  );

  modport slave (
    input  Rs_D, Rt_D, Rs_E, Rt_E, writeReg_E, writeReg_M, writeReg_W,
           regWrite_E, regWrite_M, regWrite_W, memToReg_E, memToReg_M,
           branch_D, pcSrc_D, md_start_E,
    output forwardA_E, forwardB_E, forwardA_D, forwardB_D,
           stall_F, stall_D, stall_E, flush_D, flush_E, flush_M,
           md_busy, md_done, md_state
`ifdef HAZARD_PERF_CNT_EN
         , stall_cycles, flush_count
`endif
  );

endinterface

// File: rtl/md_sequencer.sv
// Multi-cycle mult/div occupancy sequencer: holds the execute stage for
// MD_LATENCY-1 cycles, then strobes md_done for one cycle.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      md_start,
  output logic      md_busy,
  output logic      md_done,
  output logic      mdstall,
  output md_state_t state
);

  localparam logic [7:0] CNT_LOAD = 8'(MD_LATENCY - 2);

  logic [7:0] cnt;

  // md_start is ignored in DONE: the finishing instruction is still in E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MD_IDLE;
      cnt     <= 8'd0;
      md_busy <= 1'b0;
      md_done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            md_busy <= 1'b1;
            if (MD_LATENCY == 2) begin
              state   <= MD_DONE;
              md_done <= 1'b1;
            end else begin
              state <= MD_BUSY;
              cnt   <= CNT_LOAD;
            end
          end
        end
        MD_BUSY: begin
          // Leave on the decrement that brings cnt to zero.
          cnt <= cnt - 8'd1;
          if (cnt <= 8'd1) begin
            state   <= MD_DONE;
            md_done <= 1'b1;
          end
        end
        MD_DONE: begin
          state   <= MD_IDLE;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
        default: begin
          state   <= MD_IDLE;
          cnt     <= 8'd0;
          md_busy <= 1'b0;
          md_done <= 1'b0;
        end
      endcase
    end
  end

  assign mdstall = (state == MD_IDLE && md_start) || (state == MD_BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline: forwarding,
// load-use and branch stalls, flushes and mult/div freeze. Optional HAZARD_PERF_CNT_EN.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int PERF_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  hazard_controller_if.slave  hz
);

  logic mdstall, lwstall, brstall, stall_any;

  md_sequencer #(.MD_LATENCY(MD_LATENCY)) u_md (
    .clk      (clk),
    .rst      (rst),
    .md_start (hz.md_start_E),
    .md_busy  (hz.md_busy),
    .md_done  (hz.md_done),
    .mdstall  (mdstall),
    .state    (hz.md_state)
  );

  always_comb begin
    hz.forwardA_E = fwd_sel(hz.Rs_E, hz.writeReg_M, hz.regWrite_M,
                            hz.writeReg_W, hz.regWrite_W);
    hz.forwardB_E = fwd_sel(hz.Rt_E, hz.writeReg_M, hz.regWrite_M,
                            hz.writeReg_W, hz.regWrite_W);
    hz.forwardA_D = (hz.Rs_D != REG_ZERO) && hz.regWrite_M && (hz.writeReg_M == hz.Rs_D);
    hz.forwardB_D = (hz.Rt_D != REG_ZERO) && hz.regWrite_M && (hz.writeReg_M == hz.Rt_D);
  end

  always_comb begin
    lwstall = hz.memToReg_E && (hz.Rt_E != REG_ZERO) &&
              ((hz.Rt_E == hz.Rs_D) || (hz.Rt_E == hz.Rt_D));
    // Branch compares in D, so an ALU result in E or a load in M is too late.
    brstall = hz.branch_D &&
              ((hz.regWrite_E &&
                ((hz.Rs_D != REG_ZERO && hz.writeReg_E == hz.Rs_D) ||
                 (hz.Rt_D != REG_ZERO && hz.writeReg_E == hz.Rt_D))) ||
               (hz.memToReg_M &&
                ((hz.Rs_D != REG_ZERO && hz.writeReg_M == hz.Rs_D) ||
                 (hz.Rt_D != REG_ZERO && hz.writeReg_M == hz.Rt_D))));
    stall_any = mdstall || lwstall || brstall;
  end

  assign hz.stall_E = mdstall;
  assign hz.flush_M = mdstall;
  assign hz.stall_F = stall_any;
  assign hz.stall_D = stall_any;
  // E is frozen during mult/div, so no bubble goes into it then.
  assign hz.flush_E = (lwstall || brstall) && !mdstall;
  assign hz.flush_D = hz.pcSrc_D && !stall_any;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_cycles_q, flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_any && stall_cycles_q != {PERF_W{1'b1}})
        stall_cycles_q <= stall_cycles_q + 1'b1;
      if ((hz.flush_D || hz.flush_E) && flush_count_q != {PERF_W{1'b1}})
        flush_count_q <= flush_count_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_count  = flush_count_q;
`endif

endmodule
